// File: rtl/uart_axil_master_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_axil_master_pkg : shared FSM encoding, AXI response codes and       |
// |                        uart_lite register offsets.   Rev 1.0             |
// +--------------------------------------------------------------------------+
package uart_axil_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_AW_W = 3'd1,
    ST_WR_B    = 3'd2,
    ST_RD_AR   = 3'd3,
    ST_RD_R    = 3'd4,
    ST_DONE    = 3'd5
  } state_e;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  localparam logic [7:0] UART_REG_RX      = 8'h00;
  localparam logic [7:0] UART_REG_TX      = 8'h04;
  localparam logic [7:0] UART_REG_STATUS  = 8'h08;
  localparam logic [7:0] UART_REG_CONTROL = 8'h0C;

endpackage
`default_nettype wire

// File: rtl/uart_axil_master.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_axil_master : single-outstanding AXI-Lite initiator for the         |
// |                    uart_lite cfg port, with per-transaction timeout.     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module uart_axil_master
  import uart_axil_master_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned ADDR_W         = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_we_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [31:0]       req_wdata_i,
  input  logic [3:0]        req_wstrb_i,
  output logic              resp_valid_o,
  output logic [31:0]       resp_rdata_o,
  output logic [1:0]        resp_code_o,
  output logic              resp_timeout_o,
  output logic              cfg_awvalid_o,
  output logic [ADDR_W-1:0] cfg_awaddr_o,
  input  logic              cfg_awready_i,
  output logic              cfg_wvalid_o,
  output logic [31:0]       cfg_wdata_o,
  output logic [3:0]        cfg_wstrb_o,
  input  logic              cfg_wready_i,
  input  logic              cfg_bvalid_i,
  input  logic [1:0]        cfg_bresp_i,
  output logic              cfg_bready_o,
  output logic              cfg_arvalid_o,
  output logic [ADDR_W-1:0] cfg_araddr_o,
  input  logic              cfg_arready_i,
  input  logic              cfg_rvalid_i,
  input  logic [31:0]       cfg_rdata_i,
  input  logic [1:0]        cfg_rresp_i,
  output logic              cfg_rready_o
);

  localparam bit TMO_EN = (TIMEOUT_CYCLES != 0);
  localparam int CNT_W  = TMO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TMO_EN ? TIMEOUT_CYCLES - 1 : 0);

  state_e            state_q, state_d;
  logic              req_ready_q, req_ready_d;
  logic              awvalid_q, awvalid_d;
  logic              wvalid_q, wvalid_d;
  logic              bready_q, bready_d;
  logic              arvalid_q, arvalid_d;
  logic              rready_q, rready_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic              resp_valid_q, resp_valid_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [1:0]        code_q, code_d;
  logic              tmo_q, tmo_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              tmo_hit;
  logic              abort;
  logic              aw_done;
  logic              w_done;

  // The cycle that would take the counter to TIMEOUT_CYCLES is the last one
  // in which a handshake can still complete the transaction normally.
  assign tmo_hit = TMO_EN && (cnt_q >= CNT_LAST);
  assign aw_done = !awvalid_q || cfg_awready_i;
  assign w_done  = !wvalid_q  || cfg_wready_i;

  always_comb begin
    state_d      = state_q;
    req_ready_d  = req_ready_q;
    awvalid_d    = awvalid_q;
    wvalid_d     = wvalid_q;
    bready_d     = bready_q;
    arvalid_d    = arvalid_q;
    rready_d     = rready_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    resp_valid_d = 1'b0;
    rdata_d      = rdata_q;
    code_d       = code_q;
    tmo_d        = tmo_q;
    cnt_d        = cnt_q;
    abort        = 1'b0;

    if (state_q != ST_IDLE && cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    unique case (state_q)
      ST_IDLE: begin
        if (req_valid_i && req_ready_q) begin
          addr_d      = req_addr_i;
          wdata_d     = req_wdata_i;
          wstrb_d     = req_wstrb_i;
          cnt_d       = '0;
          req_ready_d = 1'b0;
          if (req_we_i) begin
            state_d   = ST_WR_AW_W;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            bready_d  = 1'b1;
          end else begin
            state_d   = ST_RD_AR;
            arvalid_d = 1'b1;
            rready_d  = 1'b1;
          end
        end
      end

      ST_WR_AW_W: begin
        if (awvalid_q && cfg_awready_i) awvalid_d = 1'b0;
        if (wvalid_q && cfg_wready_i)   wvalid_d  = 1'b0;
        if (aw_done && w_done) begin
          state_d = ST_WR_B;
        end else if (tmo_hit) begin
          abort = 1'b1;
        end
      end

      ST_WR_B: begin
        if (cfg_bvalid_i && bready_q) begin
          bready_d     = 1'b0;
          code_d       = cfg_bresp_i;
          rdata_d      = '0;
          tmo_d        = 1'b0;
          resp_valid_d = 1'b1;
          state_d      = ST_DONE;
        end else if (tmo_hit) begin
          abort = 1'b1;
        end
      end

      ST_RD_AR: begin
        if (cfg_arready_i) begin
          arvalid_d = 1'b0;
          state_d   = ST_RD_R;
        end else if (tmo_hit) begin
          abort = 1'b1;
        end
      end

      ST_RD_R: begin
        if (cfg_rvalid_i && rready_q) begin
          rready_d     = 1'b0;
          rdata_d      = cfg_rdata_i;
          code_d       = cfg_rresp_i;
          tmo_d        = 1'b0;
          resp_valid_d = 1'b1;
          state_d      = ST_DONE;
        end else if (tmo_hit) begin
          abort = 1'b1;
        end
      end

      ST_DONE: begin
        state_d     = ST_IDLE;
        req_ready_d = 1'b1;
      end

      default: begin
        state_d     = ST_IDLE;
        req_ready_d = 1'b1;
      end
    endcase

    if (abort) begin
      awvalid_d    = 1'b0;
      wvalid_d     = 1'b0;
      bready_d     = 1'b0;
      arvalid_d    = 1'b0;
      rready_d     = 1'b0;
      rdata_d      = '0;
      code_d       = AXI_RESP_SLVERR;
      tmo_d        = 1'b1;
      resp_valid_d = 1'b1;
      state_d      = ST_DONE;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      req_ready_q  <= 1'b1;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      bready_q     <= 1'b0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      resp_valid_q <= 1'b0;
      rdata_q      <= '0;
      code_q       <= AXI_RESP_OKAY;
      tmo_q        <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      req_ready_q  <= req_ready_d;
      awvalid_q    <= awvalid_d;
      wvalid_q     <= wvalid_d;
      bready_q     <= bready_d;
      arvalid_q    <= arvalid_d;
      rready_q     <= rready_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      resp_valid_q <= resp_valid_d;
      rdata_q      <= rdata_d;
      code_q       <= code_d;
      tmo_q        <= tmo_d;
      cnt_q        <= cnt_d;
    end
  end

  assign req_ready_o    = req_ready_q;
  assign resp_valid_o   = resp_valid_q;
  assign resp_rdata_o   = rdata_q;
  assign resp_code_o    = code_q;
  assign resp_timeout_o = tmo_q;
  assign cfg_awvalid_o  = awvalid_q;
  assign cfg_awaddr_o   = addr_q;
  assign cfg_wvalid_o   = wvalid_q;
  assign cfg_wdata_o    = wdata_q;
  assign cfg_wstrb_o    = wstrb_q;
  assign cfg_bready_o   = bready_q;
  assign cfg_arvalid_o  = arvalid_q;
  assign cfg_araddr_o   = addr_q;
  assign cfg_rready_o   = rready_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_axil_master.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_uart_axil_master : directed bench with a latency-configurable         |
// |                       uart_lite-like AXI-Lite slave model.   Rev 1.0     |
// +--------------------------------------------------------------------------+
module tb_uart_axil_master;
  import uart_axil_master_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  always #5 clk = ~clk;

  logic        req_valid = 1'b0, req_ready, req_we = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [3:0]  req_wstrb = '0;
  logic        resp_valid, resp_timeout;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_code;
  logic        cfg_awvalid, cfg_awready, cfg_wvalid, cfg_wready, cfg_bvalid, cfg_bready;
  logic        cfg_arvalid, cfg_arready, cfg_rvalid, cfg_rready;
  logic [31:0] cfg_awaddr, cfg_wdata, cfg_araddr, cfg_rdata;
  logic [3:0]  cfg_wstrb;
  logic [1:0]  cfg_bresp, cfg_rresp;

  uart_axil_master #(.TIMEOUT_CYCLES(16), .ADDR_W(32)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
    .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_wstrb_i(req_wstrb),
    .resp_valid_o(resp_valid), .resp_rdata_o(resp_rdata), .resp_code_o(resp_code),
    .resp_timeout_o(resp_timeout),
    .cfg_awvalid_o(cfg_awvalid), .cfg_awaddr_o(cfg_awaddr), .cfg_awready_i(cfg_awready),
    .cfg_wvalid_o(cfg_wvalid), .cfg_wdata_o(cfg_wdata), .cfg_wstrb_o(cfg_wstrb),
    .cfg_wready_i(cfg_wready),
    .cfg_bvalid_i(cfg_bvalid), .cfg_bresp_i(cfg_bresp), .cfg_bready_o(cfg_bready),
    .cfg_arvalid_o(cfg_arvalid), .cfg_araddr_o(cfg_araddr), .cfg_arready_i(cfg_arready),
    .cfg_rvalid_i(cfg_rvalid), .cfg_rdata_i(cfg_rdata), .cfg_rresp_i(cfg_rresp),
    .cfg_rready_o(cfg_rready)
  );

  // Slave model knobs, set from the stimulus block.
  int         aw_lat = 0, w_lat = 0, r_lat = 0;
  bit         ar_en = 1'b1;
  logic [1:0] bresp_cfg = 2'b00;

  int          aw_wait, w_wait, ar_wait, r_wait;
  bit          aw_got, w_got, ar_got;
  logic [31:0] aw_addr_l, w_data_l, ar_addr_l;
  logic [31:0] ctrl_reg;
  logic        txempty;

  assign cfg_awready = cfg_awvalid && !aw_got && (aw_wait >= aw_lat);
  assign cfg_wready  = cfg_wvalid  && !w_got  && (w_wait  >= w_lat);
  assign cfg_arready = ar_en && cfg_arvalid && !ar_got && (ar_wait == 0);

  function automatic logic [31:0] reg_read(input logic [31:0] a);
    case (a[7:0])
      UART_REG_STATUS:  reg_read = {28'h0, 1'b1, txempty, 2'b00};
      UART_REG_CONTROL: reg_read = ctrl_reg;
      default:          reg_read = 32'h0;
    endcase
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      aw_wait <= 0; w_wait <= 0; ar_wait <= 0; r_wait <= 0;
      aw_got <= 1'b0; w_got <= 1'b0; ar_got <= 1'b0;
      aw_addr_l <= '0; w_data_l <= '0; ar_addr_l <= '0;
      cfg_bvalid <= 1'b0; cfg_bresp <= 2'b00;
      cfg_rvalid <= 1'b0; cfg_rdata <= '0; cfg_rresp <= 2'b00;
      ctrl_reg <= '0; txempty <= 1'b1;
    end else begin
      if (!cfg_awvalid || cfg_awready) aw_wait <= 0;
      else aw_wait <= aw_wait + 1;
      if (!cfg_wvalid || cfg_wready) w_wait <= 0;
      else w_wait <= w_wait + 1;
      if (cfg_awready) begin aw_got <= 1'b1; aw_addr_l <= cfg_awaddr; end
      if (cfg_wready)  begin w_got  <= 1'b1; w_data_l  <= cfg_wdata;  end

      if (cfg_bvalid && cfg_bready) begin
        cfg_bvalid <= 1'b0;
        aw_got <= 1'b0;
        w_got  <= 1'b0;
        if (aw_addr_l[7:0] == UART_REG_TX)      txempty  <= 1'b0;
        if (aw_addr_l[7:0] == UART_REG_CONTROL) ctrl_reg <= w_data_l;
      end else if (!cfg_bvalid && (aw_got || cfg_awready) && (w_got || cfg_wready)
                   && cfg_bready) begin
        cfg_bvalid <= 1'b1;
        cfg_bresp  <= bresp_cfg;
      end

      if (cfg_arready) begin ar_got <= 1'b1; ar_addr_l <= cfg_araddr; end
      if (cfg_rvalid && cfg_rready) begin
        cfg_rvalid <= 1'b0;
        ar_got <= 1'b0;
        r_wait <= 0;
      end else if (!cfg_rvalid && (ar_got || cfg_arready)) begin
        if (r_wait >= r_lat) begin
          cfg_rvalid <= 1'b1;
          cfg_rresp  <= AXI_RESP_OKAY;
          cfg_rdata  <= reg_read(cfg_arready ? cfg_araddr : ar_addr_l);
        end else begin
          r_wait <= r_wait + 1;
        end
      end
    end
  end

  int n_checks = 0, n_pass = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issues one request from an idle master and returns at the negedge of the
  // resp_valid cycle. lat counts clock edges after the accepting edge.
  task automatic run_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] strb, output int lat, output logic [15:0] awh,
                         output logic [15:0] wh, output int beats, output bit stable);
    int guard;
    lat = -1; awh = '0; wh = '0; beats = 0; stable = 1'b1; guard = 0;
    req_we = we; req_addr = addr; req_wdata = wdata; req_wstrb = strb; req_valid = 1'b1;
    while (!req_ready && guard < 50) begin @(negedge clk); guard++; end
    @(negedge clk);
    req_valid = 1'b0;
    for (int k = 1; k <= 64; k++) begin
      if (k <= 16) begin awh[k-1] = cfg_awvalid; wh[k-1] = cfg_wvalid; end
      if (cfg_awvalid && cfg_awaddr !== addr) stable = 1'b0;
      if (cfg_wvalid && (cfg_wdata !== wdata || cfg_wstrb !== strb)) stable = 1'b0;
      if (cfg_arvalid && cfg_araddr !== addr) stable = 1'b0;
      if ((cfg_bvalid && cfg_bready) || (cfg_rvalid && cfg_rready)) beats++;
      if (resp_valid) begin lat = k; break; end
      @(negedge clk);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, beats, n_acc, n_resp;
    logic [15:0] awh, wh;
    bit stable;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_valids", {27'h0, cfg_awvalid, cfg_wvalid, cfg_bready, cfg_arvalid, cfg_rready}, 32'h0);
    chk("rst_resp", {29'h0, resp_valid, resp_code}, 32'h0);
    chk("rst_awaddr", cfg_awaddr, 32'h0);
    chk("rst_wdata", cfg_wdata, 32'h0);
    chk("rst_rdata", resp_rdata, 32'h0);

    // Zero-wait write to CONTROL: AW and W issued together in the first cycle.
    run_req(1'b1, 32'h0C, 32'h10, 4'hF, lat, awh, wh, beats, stable);
    chk("wr_ctrl_lat", 32'(lat), 32'd3);
    chk("wr_ctrl_aw_hist", 32'(awh), 32'h0001);
    chk("wr_ctrl_w_hist", 32'(wh), 32'h0001);
    chk("wr_ctrl_beats", 32'(beats), 32'd1);
    chk("wr_ctrl_stable", 32'(stable), 32'd1);
    chk("wr_ctrl_code_tmo", {29'h0, resp_timeout, resp_code}, 32'h0);
    chk("wr_ctrl_rdata", resp_rdata, 32'h0);
    @(negedge clk);
    chk("wr_ctrl_pulse", {30'h0, resp_valid, req_ready}, 32'h1);

    run_req(1'b0, 32'h0C, 32'h0, 4'h0, lat, awh, wh, beats, stable);
    chk("rd_ctrl_lat", 32'(lat), 32'd3);
    chk("rd_ctrl_rdata", resp_rdata, 32'h10);
    chk("rd_ctrl_aw_quiet", 32'(awh), 32'h0);
    @(negedge clk);

    // TX write clears TXEMPTY; STATUS bit3 stays set.
    run_req(1'b1, 32'h04, 32'h55, 4'hF, lat, awh, wh, beats, stable);
    chk("wr_tx_lat", 32'(lat), 32'd3);
    @(negedge clk);
    run_req(1'b0, 32'h08, 32'h0, 4'h0, lat, awh, wh, beats, stable);
    chk("rd_status_bits", {30'h0, resp_rdata[3:2]}, 32'h2);
    chk("rd_status_code", {29'h0, resp_timeout, resp_code}, 32'h0);
    @(negedge clk);

    // AW ready after 3 waits, W after 1: W drops first, AW held stable.
    aw_lat = 3; w_lat = 1;
    run_req(1'b1, 32'h0C, 32'hA5, 4'h3, lat, awh, wh, beats, stable);
    chk("wr_slow_aw_hist", 32'(awh), 32'h000F);
    chk("wr_slow_w_hist", 32'(wh), 32'h0003);
    chk("wr_slow_lat", 32'(lat), 32'd6);
    chk("wr_slow_beats", 32'(beats), 32'd1);
    chk("wr_slow_stable", 32'(stable), 32'd1);
    aw_lat = 0; w_lat = 0;
    @(negedge clk);

    bresp_cfg = AXI_RESP_SLVERR;
    run_req(1'b1, 32'h0C, 32'h1, 4'hF, lat, awh, wh, beats, stable);
    chk("wr_slverr", {29'h0, resp_timeout, resp_code}, 32'h2);
    bresp_cfg = AXI_RESP_OKAY;
    @(negedge clk);

    // Read RX while the slave never raises arready.
    ar_en = 1'b0;
    run_req(1'b0, 32'(UART_REG_RX), 32'h0, 4'h0, lat, awh, wh, beats, stable);
    chk("tmo_lat", 32'(lat), 32'd17);
    chk("tmo_flags", {29'h0, resp_timeout, resp_code}, 32'h6);
    chk("tmo_rdata", resp_rdata, 32'h0);
    chk("tmo_cfg_quiet", {30'h0, cfg_arvalid, cfg_rready}, 32'h0);
    @(negedge clk);
    chk("tmo_pulse", {30'h0, resp_valid, req_ready}, 32'h1);
    ar_en = 1'b1;

    // Reset while waiting for a slow R beat.
    r_lat = 6;
    req_we = 1'b0; req_addr = 32'h0C; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rd_r_state", {30'h0, cfg_arvalid, cfg_rready}, 32'h1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_cfg_quiet", {27'h0, cfg_awvalid, cfg_wvalid, cfg_bready, cfg_arvalid, cfg_rready}, 32'h0);
    chk("abort_req_ready", 32'(req_ready), 32'd1);
    n_resp = 0;
    for (int i = 0; i < 12; i++) begin
      if (resp_valid) n_resp++;
      @(negedge clk);
    end
    chk("abort_no_resp", 32'(n_resp), 32'd0);
    r_lat = 0;

    // req_valid held high: one transaction per handshake, period 4 cycles.
    req_we = 1'b1; req_addr = 32'h0C; req_wdata = 32'h3; req_wstrb = 4'hF; req_valid = 1'b1;
    n_acc = 0; n_resp = 0;
    for (int i = 0; i < 20; i++) begin
      if (req_valid && req_ready) n_acc++;
      if (resp_valid) n_resp++;
      @(negedge clk);
    end
    req_valid = 1'b0;
    chk("hold_accepts", 32'(n_acc), 32'd5);
    chk("hold_resps", 32'(n_resp), 32'd5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
